// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow sequencer: state codes,
// default score width and frame-counter width.
package pong_pkg;

    localparam int SCORE_W_DEF = 4;
    localparam int FCNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game-flow sequencer and the pong datapath.
// There is no valid/ready handshake: every input is a level or pulse
// sampled on each clk edge, and every output follows the sequencer's
// registered state, so a consumer may sample any output on any cycle.
interface pong_game_ctrl_if #(
    parameter int SCORE_W = pong_pkg::SCORE_W_DEF
);
    logic               vsync;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic               ball_run;
    logic               ball_center;
    logic               serve_dir;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [2:0]         state;
    logic               game_over;
    logic               winner;

    // Sequencer side
    modport master (
        input  vsync, start, miss_left, miss_right,
        output ball_run, ball_center, serve_dir, score1, score2,
               state, game_over, winner
    );

    // Datapath / stimulus side
    modport slave (
        output vsync, start, miss_left, miss_right,
        input  ball_run, ball_center, serve_dir, score1, score2,
               state, game_over, winner
    );
endinterface

// File: rtl/pong_edge_det.sv
// Registered rising-edge detector. The history flop resets to 1 so an
// input already high at reset release does not register as an edge.
module pong_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic d_q;

    // Remember the previous sample of the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b1;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for pong: IDLE -> SERVE -> PLAY -> POINT -> ... -> OVER.
// Holds both scores, the serve direction and the winner, and gates the
// ball engine through ball_run / ball_center.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pong_game_ctrl_if.master     bus
);
    localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE        = SCORE_W'(1);

    logic frame_tick;
    logic start_pe;

    state_e              state_q,     state_d;
    logic [FCNT_W-1:0]   cnt_q,       cnt_d;
    logic [SCORE_W-1:0]  score1_q,    score1_d;
    logic [SCORE_W-1:0]  score2_q,    score2_d;
    logic                serve_dir_q, serve_dir_d;
    logic                winner_q,    winner_d;

    pong_edge_det u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.vsync),
        .rise  (frame_tick)
    );

    pong_edge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.start),
        .rise  (start_pe)
    );

    // Next-state, frame counting and score bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pe) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.miss_right && !bus.miss_left) begin
                    score1_d    = score1_q + ONE;
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                end else if (bus.miss_left && !bus.miss_right) begin
                    score2_d    = score2_q + ONE;
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                end else if (bus.miss_left && bus.miss_right) begin
                    // Simultaneous misses: replay the point without scoring
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        if (score1_q == WIN_VAL || score2_q == WIN_VAL) begin
                            state_d  = ST_OVER;
                            winner_d = (score2_q == WIN_VAL);
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_pe) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = 1'b0;
                    state_d     = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every phase starts counting frames from zero
        if (state_d != state_q) cnt_d = '0;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.ball_run    = (state_q == ST_PLAY);
    assign bus.ball_center = (state_q != ST_PLAY);
    assign bus.game_over   = (state_q == ST_OVER);
    assign bus.score1      = score1_q;
    assign bus.score2      = score2_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match flow followed by randomized
// play, checked cycle by cycle against a rule-level game model.
module tb_pong_game_ctrl;

  localparam int SW  = 4;
  localparam int WIN = 2;
  localparam int SF  = 3;
  localparam int PF  = 2;
  localparam int W   = 16;

  // game phases of the model, numbered as the state output codes
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

  pong_game_ctrl #(
    .SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [W-1:0] pack_obs(bit run, bit center, bit dir,
      int s1, int s2, int st, bit over, bit win);
    logic [3:0] s1v, s2v;
    logic [2:0] stv;
    s1v = s1[3:0];
    s2v = s2[3:0];
    stv = st[2:0];
    return {run, center, dir, s1v, s2v, stv, over, win};
  endfunction

  function automatic logic [W-1:0] dut_obs();
    return {bus.ball_run, bus.ball_center, bus.serve_dir, bus.score1,
            bus.score2, bus.state, bus.game_over, bus.winner};
  endfunction

  task automatic report_cmp(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got run=%b ctr=%b dir=%b s1=%0d s2=%0d st=%0d over=%b win=%b exp run=%b ctr=%b dir=%b s1=%0d s2=%0d st=%0d over=%b win=%b",
        name, $time, got[15], got[14], got[13], got[12:9], got[8:5], got[4:2], got[1], got[0],
        exp[15], exp[14], exp[13], exp[12:9], exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // ---------------- reference model ----------------
  // Game rules in plain terms: a phase, frames seen in that phase,
  // two scores, serve direction and winner.
  int  m_phase;
  int  m_frames;
  int  m_score[2];
  bit  m_dir, m_win;
  bit  m_prev_vsync, m_prev_start;

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_frames = 0;
    m_score[0] = 0;
    m_score[1] = 0;
    m_dir = 1'b0;
    m_win = 1'b0;
    m_prev_vsync = 1'b1;
    m_prev_start = 1'b1;
  endfunction

  function automatic logic [W-1:0] model_obs();
    return pack_obs(m_phase == P_PLAY, m_phase != P_PLAY, m_dir, m_score[0], m_score[1],
                    m_phase, m_phase == P_OVER, m_win);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit new_frame, pressed;
        int next_phase;
        new_frame = bus.vsync && !m_prev_vsync;
        pressed   = bus.start && !m_prev_start;
        m_prev_vsync = bus.vsync;
        m_prev_start = bus.start;
        next_phase = m_phase;
        case (m_phase)
          P_IDLE:  if (pressed) next_phase = P_SERVE;
          P_SERVE: if (new_frame) begin
                     m_frames++;
                     if (m_frames == SF) next_phase = P_PLAY;
                   end
          P_PLAY: begin
            if (bus.miss_right && !bus.miss_left) begin
              m_score[0]++; m_dir = 1'b1; next_phase = P_POINT;
            end else if (bus.miss_left && !bus.miss_right) begin
              m_score[1]++; m_dir = 1'b0; next_phase = P_POINT;
            end else if (bus.miss_left && bus.miss_right) begin
              next_phase = P_POINT;
            end
          end
          P_POINT: if (new_frame) begin
                     m_frames++;
                     if (m_frames == PF) begin
                       if (m_score[0] == WIN || m_score[1] == WIN) begin
                         next_phase = P_OVER;
                         m_win = (m_score[1] == WIN);
                       end else begin
                         next_phase = P_SERVE;
                       end
                     end
                   end
          P_OVER: if (pressed) begin
                    m_score[0] = 0; m_score[1] = 0; m_dir = 1'b0; next_phase = P_SERVE;
                  end
          default: next_phase = P_IDLE;
        endcase
        if (next_phase != m_phase) m_frames = 0;
        m_phase = next_phase;
      end
      exp_q.push_back(model_obs());
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) report_cmp("cycle_out", dut_obs(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic frame(int gap);
    bus.vsync = 1'b1;
    step();
    bus.vsync = 1'b0;
    repeat (gap) step();
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) frame($urandom_range(1, 3));
  endtask

  task automatic pulse_miss(bit left, bit right);
    bus.miss_left = left;
    bus.miss_right = right;
    step();
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.vsync = 1'b1;
    bus.start = 1'b0;
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    rst_n = 1'b0;
    #2;
    report_cmp("reset_values", dut_obs(), pack_obs(0, 1, 0, 0, 0, P_IDLE, 0, 0));
    repeat (3) step();
    // release reset with vsync held high: no frame may be counted
    rst_n = 1'b1;
    repeat (3) step();
    bus.vsync = 1'b0;
    step();

    // start held for five clocks
    bus.start = 1'b1;
    repeat (5) step();
    bus.start = 1'b0;
    step();
    frames(SF);                       // SERVE -> PLAY

    pulse_miss(1'b0, 1'b1);           // player 1 scores
    frames(PF);                       // POINT -> SERVE
    frames(SF);

    pulse_miss(1'b1, 1'b1);           // simultaneous miss, no score
    frames(PF);
    pulse_start();                    // ignored in SERVE
    frames(SF);
    pulse_start();                    // ignored in PLAY

    pulse_miss(1'b1, 1'b0);           // player 2: 1
    frames(PF);
    frames(SF);
    pulse_miss(1'b1, 1'b0);           // player 2: 2 -> match point
    frames(PF);                       // -> OVER, winner = player 2
    repeat (4) step();
    pulse_miss(1'b0, 1'b1);           // ignored in OVER

    pulse_start();                    // new match
    frames(SF);
    repeat (2) step();

    // asynchronous reset in the middle of PLAY
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    report_cmp("async_reset_mid_play", dut_obs(), pack_obs(0, 1, 0, 0, 0, P_IDLE, 0, 0));
    step();
    rst_n = 1'b1;
    step();

    // randomized play, with occasional resets
    for (int c = 0; c < 4000; c++) begin
      bus.vsync      = ($urandom_range(0, 3) == 0);
      bus.start      = ($urandom_range(0, 39) == 0);
      bus.miss_left  = ($urandom_range(0, 24) == 0);
      bus.miss_right = ($urandom_range(0, 24) == 0);
      rst_n          = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.vsync = 1'b0;
    bus.start = 1'b0;
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the pong datapath. It tracks frames from the vsync rising edge and runs the match as IDLE -> SERVE -> PLAY -> POINT -> ... -> OVER. It holds both scores and gates the ball engine through ball_run and ball_center. Paddle and ball rendering stay in the datapath; this block decides when the ball moves, where it restarts, and when the match ends.

Parameters:
SCORE_W, 4, width of each score counter
WIN_SCORE, 7, points needed to win (1..2^SCORE_W-1)
SERVE_FRAMES, 60, frames the ball is held at centre before launch (1..255)
POINT_FRAMES, 30, frames of pause after a point (1..255)

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  reset
vsync  in  1  frame sync, same clock domain, active-high pulse
start  in  1  start button, synchronous level
miss_left  in  1  level; ball passed left paddle, so player 2 scores
miss_right  in  1  level; ball passed right paddle, so player 1 scores
ball_run  out  1  ball motion enable
ball_center  out  1  force ball to centre position
serve_dir  out  1  launch direction, 1 = toward right
score1  out  SCORE_W  player 1 score
score2  out  SCORE_W  player 2 score
state  out  3  current state code
game_over  out  1  high in OVER
winner  out  1  0 = player 1, 1 = player 2; valid while game_over

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; scores = 0; serve_dir = 0; winner = 0; frame counter = 0.
  - vsync_q and start_q reset to 1, so there is no spurious edge at reset release.
- Edge detection:
  - frame_tick = vsync & ~vsync_q, one cycle per frame.
  - start_pe = start & ~start_q.
- State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Codes 5-7 go to IDLE on the next clk.
- Frame counter: 8 bits. Cleared on every state change. Increments on frame_tick only in SERVE and POINT.
- IDLE: start_pe -> SERVE.
- SERVE: frame_tick while count == SERVE_FRAMES-1 -> PLAY.
- PLAY, evaluated every clk:
  - miss_right & ~miss_left: score1+1, serve_dir <= 1, then POINT.
  - miss_left & ~miss_right: score2+1, serve_dir <= 0, then POINT.
  - Both high in the same cycle: no score change, serve_dir unchanged, then POINT.
- POINT: frame_tick while count == POINT_FRAMES-1 -> next state:
  - OVER if either score == WIN_SCORE; winner <= (score2 == WIN_SCORE).
  - Otherwise SERVE.
- OVER: start_pe -> clear both scores, serve_dir <= 0, then SERVE.
- Ignored events: start_pe outside IDLE/OVER; miss_* outside PLAY.
- A score increment never exceeds WIN_SCORE. WIN_SCORE is checked at the POINT exit, so no wrap is possible.
- Outputs are registered or decoded directly from the state register:
  - ball_run = (state == PLAY).
  - ball_center = (state != PLAY).
  - game_over = (state == OVER).
- Latency: each state transition and score update is visible on the clk edge after the triggering input cycle.
- Reset mid-game: asynchronous return to the reset values; a vsync held high through reset does not produce a tick.

Decomposition:
- Shared package pong_pkg: state encoding localparams (ST_IDLE..ST_OVER), SCORE_W default, and a frame-counter width constant.
- One natural sub-module, pong_edge_det (registered rising-edge detector with reset value 1). It is instantiated twice, for vsync and start.

Test Plan:
1. Reset, then start=1 for 5 clks, with SERVE_FRAMES=3 -> state goes 0 -> 1; ball_center=1. After the 3rd vsync rise, state=2 and ball_run=1.
2. In PLAY, pulse miss_right for 1 clk -> score1=1, serve_dir=1, state=3. With POINT_FRAMES=2, state=1 after the 2nd vsync edge.
3. In PLAY, assert miss_left and miss_right together -> both scores unchanged, state=3.
4. WIN_SCORE=2: two miss_left points -> score2=2. After the POINT delay: state=4, game_over=1, winner=1, ball_center=1.
5. In OVER, pulse start -> scores=0, serve_dir=0, state=1. Toggling start during PLAY and SERVE has no effect.
6. Hold vsync=1 across rst_n deassertion -> no frame tick. Drop rst_n mid-PLAY -> all outputs return to reset values immediately.
